// File: rtl/detector_sched_pkg.sv
// Shared types and round-robin helper for the detector scheduler and its arbiter.
// The grant search is written for up to MAX_CH requesters so one function serves every width.
package detector_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam int unsigned MAX_CH = 16;

   // Returns the index of the first set req bit after last_grant (with wrap), or -1 if none.
   function automatic int rr_next_grant(input logic [MAX_CH-1:0] req,
                                        input int unsigned       last_grant,
                                        input int unsigned       num_ch);
      int          sel;
      int unsigned idx;
      logic [3:0]  idx4;
      sel = -1;
      for (int unsigned k = 1; k <= MAX_CH; k++) begin
         idx  = (last_grant + k) % num_ch;
         idx4 = 4'(idx);
         if (k <= num_ch && sel < 0 && req[idx4]) begin
            sel = int'(idx);
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus encoded index, searching
// upward from the requester after last_grant.
module rr_arbiter
   import detector_sched_pkg::*;
#(
   parameter  int NUM_CH = 4,
   localparam int CH_W   = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   last_grant,
   output logic [NUM_CH-1:0] grant,
   output logic [CH_W-1:0]   grant_idx,
   output logic              grant_valid
);

   logic [MAX_CH-1:0] req_ext;
   int                sel;

   always_comb begin
      req_ext               = '0;
      req_ext[NUM_CH-1:0]   = req;
      sel                   = rr_next_grant(req_ext, 32'(last_grant), NUM_CH);
      grant_valid           = (sel >= 0);
      grant_idx             = grant_valid ? CH_W'(sel) : '0;
      grant                 = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         grant[i] = grant_valid && (sel == i);
      end
   end

endmodule

// File: rtl/detector_scheduler.sv
// Shares one anomaly detector between NUM_CH sensor channels: round-robin accept,
// issue, wait for verdict with timeout, and per-channel sticky flags / saturating counts.
module detector_scheduler
   import detector_sched_pkg::*;
#(
   parameter  int NUM_CH  = 4,
   parameter  int DATA_W  = 8,
   parameter  int CNT_W   = 8,
   parameter  int TIMEOUT = 64,
   localparam int CH_W    = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        ch_valid,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   output logic [NUM_CH-1:0]        ch_ready,
   input  logic [NUM_CH-1:0]        ch_enable,
   output logic                     det_valid,
   output logic [DATA_W-1:0]        det_data,
   output logic [CH_W-1:0]          det_ch,
   input  logic                     det_ready,
   input  logic                     det_done,
   input  logic                     det_anomaly,
   output logic                     result_valid,
   output logic [CH_W-1:0]          result_ch,
   output logic                     result_anomaly,
   output logic [NUM_CH-1:0]        anom_flag,
   output logic [NUM_CH*CNT_W-1:0]  anom_count,
   output logic                     timeout_err,
   input  logic                     clear,
   output logic                     busy
);

   localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   state_t              state_q, state_d;
   logic [CH_W-1:0]     last_grant_q, last_grant_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic                result_valid_q, result_valid_d;
   logic [CH_W-1:0]     result_ch_q, result_ch_d;
   logic                result_anomaly_q, result_anomaly_d;
   logic                timeout_err_q, timeout_err_d;

   logic [NUM_CH-1:0]   req;
   logic [NUM_CH-1:0]   grant;
   logic [CH_W-1:0]     grant_idx;
   logic                grant_valid;
   logic                accept;
   logic                verdict;
   logic                timed_out;

   assign req = ch_valid & ch_enable;

   rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .req         (req),
      .last_grant  (last_grant_q),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   assign accept    = (state_q == IDLE) && grant_valid;
   assign verdict   = (state_q == WAIT) && det_done;
   // A verdict arriving on the last allowed cycle still wins over the timeout.
   assign timed_out = (state_q == WAIT) && !det_done && (timer_q == TMR_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_valid)            state_d = ISSUE;
         ISSUE:   if (det_ready)              state_d = WAIT;
         WAIT:    if (det_done || timed_out)  state_d = IDLE;
         default:                             state_d = IDLE;
      endcase
   end

   always_comb begin
      ch_ready  = '0;
      det_valid = 1'b0;
      busy      = (state_q != IDLE);
      if (state_q == IDLE) begin
         ch_ready = grant;
      end
      if (state_q == ISSUE) begin
         det_valid = 1'b1;
      end
   end

   always_comb begin
      last_grant_d     = last_grant_q;
      ch_d             = ch_q;
      data_d           = data_q;
      timer_d          = timer_q;
      if (accept) begin
         last_grant_d = grant_idx;
         ch_d         = grant_idx;
         for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
               data_d = ch_data[i*DATA_W +: DATA_W];
            end
         end
      end
      if (state_q == ISSUE && det_ready) begin
         timer_d = '0;
      end else if (state_q == WAIT) begin
         timer_d = timer_q + TMR_W'(1);
      end
      result_valid_d   = verdict;
      result_ch_d      = verdict ? ch_q : result_ch_q;
      result_anomaly_d = verdict ? det_anomaly : result_anomaly_q;
      timeout_err_d    = clear ? 1'b0 : (timed_out | timeout_err_q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_grant_q     <= CH_W'(NUM_CH - 1);
         ch_q             <= '0;
         data_q           <= '0;
         timer_q          <= '0;
         result_valid_q   <= 1'b0;
         result_ch_q      <= '0;
         result_anomaly_q <= 1'b0;
         timeout_err_q    <= 1'b0;
      end else begin
         last_grant_q     <= last_grant_d;
         ch_q             <= ch_d;
         data_q           <= data_d;
         timer_q          <= timer_d;
         result_valid_q   <= result_valid_d;
         result_ch_q      <= result_ch_d;
         result_anomaly_q <= result_anomaly_d;
         timeout_err_q    <= timeout_err_d;
      end
   end

   // Per-channel sticky flag and saturating counter; clear beats a same-cycle verdict.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic             flag_q, flag_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             hit;

      always_comb begin
         hit    = verdict && det_anomaly && (ch_q == CH_W'(gi));
         flag_d = flag_q;
         cnt_d  = cnt_q;
         if (clear) begin
            flag_d = 1'b0;
            cnt_d  = '0;
         end else if (hit) begin
            flag_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            flag_q <= 1'b0;
            cnt_q  <= '0;
         end else begin
            flag_q <= flag_d;
            cnt_q  <= cnt_d;
         end
      end

      assign anom_flag[gi]                 = flag_q;
      assign anom_count[gi*CNT_W +: CNT_W] = cnt_q;
   end

   assign det_data       = data_q;
   assign det_ch         = ch_q;
   assign result_valid   = result_valid_q;
   assign result_ch      = result_ch_q;
   assign result_anomaly = result_anomaly_q;
   assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_detector_scheduler.sv
// Directed, table-driven bench for detector_scheduler (4 channels, 8-bit data/counters, timeout 64).
module tb_detector_scheduler;

   logic        clk;
   logic        reset;
   logic [3:0]  ch_valid;
   logic [31:0] ch_data;
   logic [3:0]  ch_ready;
   logic [3:0]  ch_enable;
   logic        det_valid;
   logic [7:0]  det_data;
   logic [1:0]  det_ch;
   logic        det_ready;
   logic        det_done;
   logic        det_anomaly;
   logic        result_valid;
   logic [1:0]  result_ch;
   logic        result_anomaly;
   logic [3:0]  anom_flag;
   logic [31:0] anom_count;
   logic        timeout_err;
   logic        clear;
   logic        busy;

   int tests = 0;
   int fails = 0;

   detector_scheduler #(
      .NUM_CH  (4),
      .DATA_W  (8),
      .CNT_W   (8),
      .TIMEOUT (64)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .ch_valid       (ch_valid),
      .ch_data        (ch_data),
      .ch_ready       (ch_ready),
      .ch_enable      (ch_enable),
      .det_valid      (det_valid),
      .det_data       (det_data),
      .det_ch         (det_ch),
      .det_ready      (det_ready),
      .det_done       (det_done),
      .det_anomaly    (det_anomaly),
      .result_valid   (result_valid),
      .result_ch      (result_ch),
      .result_anomaly (result_anomaly),
      .anom_flag      (anom_flag),
      .anom_count     (anom_count),
      .timeout_err    (timeout_err),
      .clear          (clear),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails + 1);
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [3:0]  valid;
      logic [3:0]  enable;
      logic [31:0] data;
      logic        anomaly;
      int          gap;
      logic [3:0]  exp_ready;
      logic [1:0]  exp_ch;
      logic [7:0]  exp_data;
   } vec_t;

   vec_t vecs [10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ch_ready"},       32'(ch_ready),       32'h0);
      check({tag, "_det_valid"},      32'(det_valid),      32'h0);
      check({tag, "_det_data"},       32'(det_data),       32'h0);
      check({tag, "_det_ch"},         32'(det_ch),         32'h0);
      check({tag, "_result_valid"},   32'(result_valid),   32'h0);
      check({tag, "_result_ch"},      32'(result_ch),      32'h0);
      check({tag, "_result_anomaly"}, 32'(result_anomaly), 32'h0);
      check({tag, "_anom_flag"},      32'(anom_flag),      32'h0);
      check({tag, "_anom_count"},     anom_count,          32'h0);
      check({tag, "_timeout_err"},    32'(timeout_err),    32'h0);
      check({tag, "_busy"},           32'(busy),           32'h0);
   endtask

   // One full accept/issue/wait/verdict transaction starting in IDLE, #1 after an edge.
   task automatic do_txn(input logic [3:0] v, input logic [3:0] en, input logic [31:0] d,
                         input logic a, input int gap, input logic clr,
                         input logic [3:0] exp_rdy, input logic [1:0] exp_ch, input logic [7:0] exp_d);
      ch_valid  = v;
      ch_enable = en;
      ch_data   = d;
      #1;
      check("ch_ready", 32'(ch_ready), 32'(exp_rdy));
      check("idle_busy", 32'(busy), 32'h0);
      tick();
      ch_valid = '0;
      check("det_valid", 32'(det_valid), 32'h1);
      check("det_ch", 32'(det_ch), 32'(exp_ch));
      check("det_data", 32'(det_data), 32'(exp_d));
      check("ready_after_accept", 32'(ch_ready), 32'h0);
      det_ready = 1'b1;
      tick();
      det_ready = 1'b0;
      check("wait_det_valid", 32'(det_valid), 32'h0);
      for (int i = 0; i < gap; i++) begin
         check("no_early_result", 32'(result_valid), 32'h0);
         tick();
      end
      det_done    = 1'b1;
      det_anomaly = a;
      clear       = clr;
      tick();
      det_done    = 1'b0;
      det_anomaly = 1'b0;
      clear       = 1'b0;
      check("result_valid", 32'(result_valid), 32'h1);
      check("result_ch", 32'(result_ch), 32'(exp_ch));
      check("result_anomaly", 32'(result_anomaly), 32'(a));
      check("done_busy", 32'(busy), 32'h0);
      $display("[TB] txn ch=%0d data=0x%02h anomaly=%0d flags=%b", result_ch, det_data, result_anomaly, anom_flag);
   endtask

   initial begin
      int rv_seen;

      vecs[0] = '{4'b0001, 4'b1111, 32'h0000005A, 1'b1, 2, 4'b0001, 2'd0, 8'h5A};
      vecs[1] = '{4'b1111, 4'b1111, 32'hD3C2B1A0, 1'b0, 0, 4'b0010, 2'd1, 8'hB1};
      vecs[2] = '{4'b1111, 4'b1111, 32'hD3C2B1A0, 1'b1, 1, 4'b0100, 2'd2, 8'hC2};
      vecs[3] = '{4'b1111, 4'b1111, 32'hD3C2B1A0, 1'b0, 0, 4'b1000, 2'd3, 8'hD3};
      vecs[4] = '{4'b1111, 4'b1111, 32'hD3C2B1A0, 1'b0, 3, 4'b0001, 2'd0, 8'hA0};
      vecs[5] = '{4'b1111, 4'b1011, 32'hD3C2B1A0, 1'b0, 0, 4'b0010, 2'd1, 8'hB1};
      vecs[6] = '{4'b1111, 4'b1011, 32'hD3C2B1A0, 1'b1, 1, 4'b1000, 2'd3, 8'hD3};
      vecs[7] = '{4'b1111, 4'b1011, 32'hD3C2B1A0, 1'b0, 0, 4'b0001, 2'd0, 8'hA0};
      vecs[8] = '{4'b0100, 4'b1111, 32'hD3C2B1A0, 1'b0, 2, 4'b0100, 2'd2, 8'hC2};
      vecs[9] = '{4'b0011, 4'b1111, 32'hD3C2B1A0, 1'b0, 0, 4'b0001, 2'd0, 8'hA0};

      reset       = 1'b0;
      ch_valid    = '0;
      ch_enable   = 4'b1111;
      ch_data     = '0;
      det_ready   = 1'b0;
      det_done    = 1'b0;
      det_anomaly = 1'b0;
      clear       = 1'b0;
      tick();
      tick();
      check_all_zero("reset");
      reset = 1'b1;
      tick();

      // Grant order, data capture and verdict return.
      for (int i = 0; i < 10; i++) begin
         do_txn(vecs[i].valid, vecs[i].enable, vecs[i].data, vecs[i].anomaly, vecs[i].gap, 1'b0,
                vecs[i].exp_ready, vecs[i].exp_ch, vecs[i].exp_data);
         if (i == 0) begin
            check("first_flag", 32'(anom_flag), 32'h1);
            check("first_count", anom_count, 32'h00000001);
         end
      end
      check("table_flags", 32'(anom_flag), 32'hD);
      check("table_counts", anom_count, 32'h01010001);

      // Saturation of channel 2 counter (starts at 1).
      for (int i = 0; i < 300; i++) begin
         do_txn(4'b0100, 4'b1111, 32'hD3C2B1A0, 1'b1, 0, 1'b0, 4'b0100, 2'd2, 8'hC2);
         if (i == 252) check("count2_254", 32'(anom_count[23:16]), 32'd254);
         if (i == 253) check("count2_255", 32'(anom_count[23:16]), 32'd255);
      end
      check("count2_sat", 32'(anom_count[23:16]), 32'd255);
      check("count_others", {anom_count[31:24], anom_count[15:0]}, 32'h00010001);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clear_flags", 32'(anom_flag), 32'h0);
      check("clear_counts", anom_count, 32'h0);

      // Timeout: channel 1 granted (last grant was 2), detector never answers.
      ch_valid = 4'b0010;
      ch_enable = 4'b1111;
      #1;
      check("to_ready", 32'(ch_ready), 32'h2);
      tick();
      ch_valid = '0;
      check("to_det_ch", 32'(det_ch), 32'h1);
      det_ready = 1'b1;
      tick();
      det_ready = 1'b0;
      rv_seen = 0;
      for (int i = 0; i < 63; i++) begin
         if (result_valid) rv_seen++;
         tick();
      end
      check("to_busy_before", 32'(busy), 32'h1);
      check("to_err_before", 32'(timeout_err), 32'h0);
      tick();
      check("to_busy_after", 32'(busy), 32'h0);
      check("to_err_after", 32'(timeout_err), 32'h1);
      check("to_no_result", 32'(result_valid), 32'h0);
      check("to_no_result_window", 32'(rv_seen), 32'h0);
      $display("[TB] txn ch=1 timed out, timeout_err=%0d", timeout_err);

      // det_done in IDLE must be ignored.
      det_done    = 1'b1;
      det_anomaly = 1'b1;
      tick();
      det_done    = 1'b0;
      det_anomaly = 1'b0;
      check("idle_done_result", 32'(result_valid), 32'h0);
      check("idle_done_flags", 32'(anom_flag), 32'h0);

      // Next channel after the timed-out one.
      do_txn(4'b1111, 4'b1111, 32'hD3C2B1A0, 1'b1, 1, 1'b0, 4'b0100, 2'd2, 8'hC2);
      check("post_to_flag", 32'(anom_flag), 32'h4);
      check("post_to_err_sticky", 32'(timeout_err), 32'h1);

      // clear in the same cycle as an anomalous verdict.
      do_txn(4'b0001, 4'b1111, 32'hD3C2B1A0, 1'b1, 0, 1'b1, 4'b0001, 2'd0, 8'hA0);
      check("clr_verdict_flags", 32'(anom_flag), 32'h0);
      check("clr_verdict_counts", anom_count, 32'h0);
      check("clr_verdict_err", 32'(timeout_err), 32'h0);

      // Reset asserted while waiting for a verdict on channel 3.
      ch_valid = 4'b1000;
      #1;
      check("rst_ready", 32'(ch_ready), 32'h8);
      tick();
      ch_valid  = '0;
      det_ready = 1'b1;
      tick();
      det_ready = 1'b0;
      check("rst_in_wait_busy", 32'(busy), 32'h1);
      check("rst_in_wait_ch", 32'(det_ch), 32'h3);
      reset = 1'b0;
      #1;
      check_all_zero("rst_wait");
      tick();
      reset    = 1'b1;
      ch_valid = 4'b1111;
      #1;
      check("rst_first_grant", 32'(ch_ready), 32'h1);
      tick();
      ch_valid = '0;
      check("rst_first_ch", 32'(det_ch), 32'h0);
      $display("[TB] txn reset-in-wait, first grant ch=%0d", det_ch);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/detector_scheduler.md
# detector_scheduler

Round-robin scheduler that shares one anomaly-detection engine (FIFO + isolation-tree state machine) between several sensor channels. It accepts samples from NUM_CH valid/ready channel ports, issues them one at a time to the detector, and waits for each verdict with a timeout. It returns each verdict tagged with its channel and keeps per-channel sticky anomaly flags and saturating anomaly counters. It sits between the sensor front-ends and the detector instance.

## Interface
- NUM_CH, 4: number of sensor channels (2..16)
- DATA_W, 8: sample width
- CNT_W, 8: per-channel anomaly counter width
- TIMEOUT, 64: maximum WAIT cycles for det_done (≥2)
- CH_W, $clog2(NUM_CH): derived channel-index width, not overridden
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- ch_valid  in  NUM_CH  per-channel sample valid
- ch_data  in  NUM_CH*DATA_W  samples; channel i is at [i*DATA_W +: DATA_W]
- ch_ready  out  NUM_CH  per-channel accept, one-hot or zero
- ch_enable  in  NUM_CH  channel enable mask (configuration)
- det_valid  out  1  sample offered to detector
- det_data  out  DATA_W  held sample
- det_ch  out  CH_W  channel of held sample
- det_ready  in  1  detector accepts sample
- det_done  in  1  one-cycle verdict strobe
- det_anomaly  in  1  verdict, qualified by det_done
- result_valid  out  1  one-cycle verdict pulse
- result_ch  out  CH_W  channel of verdict
- result_anomaly  out  1  verdict value
- anom_flag  out  NUM_CH  sticky per-channel anomaly seen
- anom_count  out  NUM_CH*CNT_W  saturating per-channel anomaly counts
- timeout_err  out  1  sticky: a verdict timed out
- clear  in  1  synchronous clear of anom_flag, anom_count, timeout_err
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: req = ch_valid & ch_enable. If req is non-zero, grant the first set bit searching from (last_grant+1) mod NUM_CH upward with wrap. ch_ready[g]=1 is combinational in that cycle. Latch ch_data[g] and g, set last_grant=g, go to ISSUE. ch_ready is 0 in every other state.
- ISSUE: det_valid=1, with det_data/det_ch stable. When det_ready=1, clear the timer and go to WAIT.
- WAIT: det_done=1 ends the transaction.
  - Register result_valid=1, result_ch, result_anomaly.
  - If det_anomaly=1: set anom_flag[ch] and increment anom_count[ch], saturating at 2^CNT_W−1.
  - Go to IDLE.
- WAIT timeout: if the timer reaches TIMEOUT−1 without det_done, set timeout_err, emit no result_valid, discard the sample, and go to IDLE.
- det_done outside WAIT is ignored.
- Disabled channels are never granted. Clearing ch_enable mid-transaction does not abort the transaction.
- clear has priority over a same-cycle verdict update: flags, counts and timeout_err go to 0. result_valid still pulses.
- Reset at any time: state IDLE, last_grant=NUM_CH−1 (channel 0 first), hold registers 0.

## Timing
- Reset values: ch_ready 0, det_valid 0, det_data 0, det_ch 0, result_valid 0, result_ch 0, result_anomaly 0, anom_flag 0, anom_count 0, timeout_err 0, busy 0.
- Accept at cycle T (ch_ready & ch_valid) → det_valid from T+1.
- det_ready at cycle R → WAIT from R+1. The timer counts from R+1.
- det_done at cycle D → result_valid, flag/count update and IDLE all at D+1. The next accept is possible at D+1.
- Timeout: timeout_err is set and the block is back in IDLE TIMEOUT cycles after entering WAIT.
- Throughput: at most one sample per 3 cycles.

## Structure
- Shared package detector_sched_pkg: state enum (IDLE, ISSUE, WAIT), and a function computing the next round-robin grant from req and last_grant.
- One sub-module: rr_arbiter (combinational grant from req and pointer, NUM_CH parameter). Reusable for other shared resources.
- Everything else (FSM, hold registers, timer, counters) stays in detector_scheduler.

## Test plan
- Single channel: ch_valid=0001, data 0x5A, det_ready=1, det_done with anomaly=1 3 cycles later → det_data=0x5A, det_ch=0, result_valid one cycle with ch=0 and anomaly=1, anom_flag=0001, count[0]=1.
- All four channels valid continuously, detector answering every cycle → grant order 0,1,2,3,0; with ch_enable=1011, order 0,1,3,0.
- 300 anomalies on channel 2 with CNT_W=8 → anom_count[2] holds 255. Then clear=1 → all counts and flags 0.
- No det_done for 64 cycles after det_ready → timeout_err=1, no result_valid, busy=0, next channel granted.
- clear in the same cycle as det_done with anomaly=1 → result_valid=1, anom_flag=0, count=0.
- Reset asserted in WAIT → all outputs 0 immediately. After release, the first grant goes to channel 0.
